// File: rtl/seq_sub_nbit.sv
// -----------------------------------------------------------------------------
// seq_sub_nbit
//
// Multi-cycle subtractor: Diff = X - Y - Bin (mod 2^WIDTH), CHUNK bits per
// clock. The borrow between chunks is carried in a register, so the logic
// depth per cycle is that of a CHUNK-bit subtractor regardless of WIDTH.
//
// Optional feature macro: SEQ_SUB_OVF_EN
//   defined   -> Ovf port and signed-overflow register are present
//   undefined -> no Ovf port, no overflow logic
//
// Handshakes (both sides): a transfer happens on the rising edge where
// valid and ready are both 1. A producer holds valid and data stable until
// that edge; ready never depends combinationally on valid.
//
// Parameters:
//   WIDTH      operand/result width, >= 1
//   CHUNK      bits per cycle, 1 <= CHUNK <= WIDTH, WIDTH % CHUNK == 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on X, Y, Bin
//   in_ready   block can accept operands (IDLE only)
//   X, Y       minuend, subtrahend
//   Bin        borrow-in applied to chunk 0
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//   Diff       registered difference
//   Bout       registered borrow out of the MSB chunk
//   Ovf        registered signed overflow (SEQ_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module seq_sub_nbit #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       state_dbg,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
`ifdef SEQ_SUB_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   generate
      if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
         $error("seq_sub_nbit: illegal WIDTH/CHUNK combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic             borrow;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] acc;      // result under construction, chunk by chunk

   // Current-chunk datapath
   int               base;
   logic [WIDTH-1:0] x_sh;
   logic [WIDTH-1:0] y_sh;
   logic [CHUNK-1:0] x_ch;
   logic [CHUNK-1:0] y_ch;
   logic [CHUNK:0]   sub;
   logic [CHUNK-1:0] d_ch;
   logic             b_ch;
   logic [WIDTH-1:0] chunk_mask;
   logic [WIDTH-1:0] acc_next;
   logic             last;

   always_comb begin
      base       = int'(idx) * CHUNK;
      x_sh       = x_q >> base;
      y_sh       = y_q >> base;
      x_ch       = x_sh[CHUNK-1:0];
      y_ch       = y_sh[CHUNK-1:0];
      // One extra bit on the left: it reads 1 exactly when the chunk
      // difference went negative, i.e. the borrow into the next chunk.
      sub        = {1'b0, x_ch} - {1'b0, y_ch} - {{CHUNK{1'b0}}, borrow};
      d_ch       = sub[CHUNK-1:0];
      b_ch       = sub[CHUNK];
      chunk_mask = {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}} << base;
      acc_next   = (acc & ~chunk_mask) |
                   (({{(WIDTH-CHUNK){1'b0}}, d_ch}) << base);
      last       = (idx == IW'(NCH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         borrow <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
         acc    <= '0;
         Diff   <= '0;
         Bout   <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
         Ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_q    <= X;
                  y_q    <= Y;
                  borrow <= Bin;
                  idx    <= '0;
                  acc    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               acc    <= acc_next;
               borrow <= b_ch;
               if (last) begin
                  // Outputs move only here, so they stay put through
                  // DONE, IDLE and the next RUN.
                  idx   <= '0;
                  Diff  <= acc_next;
                  Bout  <= b_ch;
`ifdef SEQ_SUB_OVF_EN
                  Ovf   <= (x_q[WIDTH-1] ^ y_q[WIDTH-1]) &
                           (x_q[WIDTH-1] ^ acc_next[WIDTH-1]);
`endif
                  state <= S_DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Pure state decode: no input reaches these outputs combinationally.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_sub_nbit.sv
// -----------------------------------------------------------------------------
// tb_seq_sub_nbit
//
// Directed bench for seq_sub_nbit (WIDTH=16, CHUNK=4) plus three WIDTH=8
// instances (CHUNK=1, 2, 8) driven with random operands against an
// arithmetic reference. Build with +define+SEQ_SUB_OVF_EN to also check Ovf.
// -----------------------------------------------------------------------------
module tb_seq_sub_nbit;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- main DUT (16/4) ----------------
   logic        in_valid;
   logic        in_ready;
   logic [15:0] X;
   logic [15:0] Y;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  state_dbg;
   logic [15:0] Diff;
   logic        Bout;
   logic        Ovf;

   seq_sub_nbit #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .Y         (Y),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_dbg (state_dbg),
      .Diff      (Diff),
      .Bout      (Bout)
`ifdef SEQ_SUB_OVF_EN
      ,
      .Ovf       (Ovf)
`endif
   );

`ifndef SEQ_SUB_OVF_EN
   assign Ovf = 1'b0;
`endif

   // ---------------- sweep DUTs (8/1, 8/2, 8/8) ----------------
   logic       sw_in_valid  [3];
   logic       sw_in_ready  [3];
   logic [7:0] sw_x         [3];
   logic [7:0] sw_y         [3];
   logic       sw_bin       [3];
   logic       sw_out_valid [3];
   logic       sw_out_ready [3];
   logic [1:0] sw_state     [3];
   logic [7:0] sw_diff      [3];
   logic       sw_bout      [3];
   logic       sw_ovf       [3];

   for (genvar g = 0; g < 3; g++) begin : g_sw
      seq_sub_nbit #(.WIDTH(8), .CHUNK(g == 0 ? 1 : (g == 1 ? 2 : 8))) u_sw (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (sw_in_valid[g]),
         .in_ready  (sw_in_ready[g]),
         .X         (sw_x[g]),
         .Y         (sw_y[g]),
         .Bin       (sw_bin[g]),
         .out_valid (sw_out_valid[g]),
         .out_ready (sw_out_ready[g]),
         .state_dbg (sw_state[g]),
         .Diff      (sw_diff[g]),
         .Bout      (sw_bout[g])
`ifdef SEQ_SUB_OVF_EN
         ,
         .Ovf       (sw_ovf[g])
`endif
      );
`ifndef SEQ_SUB_OVF_EN
      assign sw_ovf[g] = 1'b0;
`endif
   end

   // ---------------- scoreboard ----------------
   logic [17:0] exp_q[$];   // {ovf, bout, diff}
   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks (main DUT) ----------------
   // Offers one operand set, then waits (bounded) for out_valid; returns at
   // the negedge where out_valid is first seen, result not yet consumed.
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bin,
                       input logic [15:0] ed, input logic eb, input logic eo);
      int lat;
      exp_q.push_back({eo, eb, ed});
      @(negedge clk);
      X = x; Y = y; Bin = bin; in_valid = 1'b1;
      check("accept_ready", in_ready, 1);
      @(posedge clk);              // accept edge
      @(negedge clk);
      in_valid = 1'b0;
      X = 16'($urandom); Y = 16'($urandom); Bin = 1'($urandom_range(0, 1));
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 5);
   endtask

   // Consumes the result currently presented and checks the release.
   task automatic take();
      logic [17:0] e;
      e = exp_q.pop_front();
      check("out_valid", out_valid, 1);
      check("diff", Diff, e[15:0]);
      check("bout", Bout, e[16]);
`ifdef SEQ_SUB_OVF_EN
      check("ovf", Ovf, e[17]);
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("ready_back", in_ready, 1);
   endtask

   // ---------------- driver task (sweep DUTs, out_ready held high) -------
   task automatic sweep_op(input int k, input logic [7:0] x, input logic [7:0] y, input logic bin);
      logic [8:0] r;
      logic       eo;
      int         lat;
      int         exp_lat;
      r       = {1'b0, x} - {1'b0, y} - {8'd0, bin};
      eo      = (x[7] ^ y[7]) & (x[7] ^ r[7]);
      exp_lat = (k == 0) ? 9 : ((k == 1) ? 5 : 2);
      @(negedge clk);
      sw_x[k] = x; sw_y[k] = y; sw_bin[k] = bin; sw_in_valid[k] = 1'b1;
      check($sformatf("sw%0d_ready", k), sw_in_ready[k], 1);
      @(negedge clk);
      sw_in_valid[k] = 1'b0;
      sw_x[k] = 8'($urandom); sw_y[k] = 8'($urandom);
      lat = 1;
      while (!sw_out_valid[k] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("sw%0d_latency", k), lat, exp_lat);
      check($sformatf("sw%0d_diff", k), sw_diff[k], r[7:0]);
      check($sformatf("sw%0d_bout", k), sw_bout[k], r[8]);
`ifdef SEQ_SUB_OVF_EN
      check($sformatf("sw%0d_ovf", k), sw_ovf[k], eo);
`endif
      @(negedge clk);
      check($sformatf("sw%0d_pulse", k), sw_out_valid[k], 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      X = '0; Y = '0; Bin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sw_in_valid[i] = 1'b0; sw_out_ready[i] = 1'b1;
         sw_x[i] = '0; sw_y[i] = '0; sw_bin[i] = 1'b0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_state", state_dbg, 2'd0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", Diff, 16'h0000);
      check("rst_bout", Bout, 0);
      rst_n = 1'b1;

      // Directed vectors: x, y, bin -> diff, bout, ovf
      send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0); take();
      send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0); take();
      send(16'h0100, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0); take();
      send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0); take();
      send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1); take();
      send(16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1); take();
      send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0); take();

      // Backpressure in DONE with a competing operand offered
      send(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);
      X = 16'h1111; Y = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_diff", Diff, 16'h9999);
         check("bp_bout", Bout, 0);
      end
      in_valid = 1'b0;
      take();
      @(negedge clk);
      check("bp_not_taken_state", state_dbg, 2'd0);
      check("bp_not_taken_diff", Diff, 16'h9999);

      // Reset two cycles after accept
      @(negedge clk);
      X = 16'h9999; Y = 16'h1111; Bin = 1'b1; in_valid = 1'b1;
      @(posedge clk);              // accept
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_state", state_dbg, 2'd0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_diff", Diff, 16'h0000);
      check("mid_rst_bout", Bout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0); take();

      // Parameter sweep
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 200; n++) begin
            sweep_op(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
